// File: rtl/imem_pkg.sv
// Shared types and helpers for the boot-loadable instruction memory.
// Optional parity storage is enabled by defining IMEM_PARITY_EN.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } imem_state_t;

    localparam int unsigned NOP_DEFAULT = 0;

    // Even parity: the stored bit makes the XOR of data plus parity zero.
    // Narrower words are zero-extended, which leaves the parity unchanged.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-write, single-registered-read instruction RAM; contents are never reset.
module imem_ram
    import imem_pkg::*;
#(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_loadable.sv
// Boot-loadable instruction memory with registered fetch, stall/flush and range check.
// Define IMEM_PARITY_EN to store and check an even-parity bit per word.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       DEPTH     = 64,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              addr_err,
    output logic              par_err
);

    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

`ifdef IMEM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif

    imem_state_t state, state_nx;

    logic              fetch_ok;
    logic              accept;
    logic              pc_ok;
    logic              rd_en;
    logic              wr_en;
    logic              enter_load;
    logic              hold;
    logic              set_nop;
    logic              out_nop;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        fetch_ok   = 1'b0;
        accept     = 1'b0;
        pc_ok      = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        enter_load = 1'b0;
        hold       = 1'b0;
        set_nop    = 1'b0;

        case (state)
            IDLE: begin
                if (load_en) begin
                    state_nx = LOAD;
                end else if (fetch_req) begin
                    state_nx = RUN;
                end
            end
            LOAD: begin
                if (!load_en) begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (load_en) begin
                    state_nx = LOAD;
                end
            end
            default: state_nx = IDLE;
        endcase

        fetch_ok   = (state != LOAD) && !load_en;
        enter_load = (state != LOAD) && load_en;
        pc_ok      = ({1'b0, fetch_pc} < DEPTH_V);
        accept     = fetch_ok && fetch_req && !stall && !flush;
        rd_en      = accept && pc_ok;
        wr_en      = rst && (state == LOAD) && load_we && ({1'b0, load_addr} < DEPTH_V);
        hold       = fetch_ok && stall && !flush;
        set_nop    = flush || (!fetch_ok && load_en) || (accept && !pc_ok);
    end

    // instr is the RAM read register gated by out_nop, so a stall holds it for free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
            out_nop     <= 1'b1;
            load_done   <= 1'b0;
            load_count  <= '0;
        end else begin
            load_done <= (state == LOAD) && !load_en;
            if (enter_load) begin
                load_count <= '0;
            end else if (wr_en && (load_count != '1)) begin
                load_count <= load_count + 1'b1;
            end
            if (!hold) begin
                instr_valid <= accept;
                addr_err    <= accept && !pc_ok;
            end
            if (set_nop) begin
                out_nop <= 1'b1;
            end else if (rd_en) begin
                out_nop <= 1'b0;
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_live;

    assign ram_wdata = {even_par(64'(load_data)), load_data};

    always_ff @(posedge clk) begin
        if (!rst) begin
            par_live <= 1'b0;
        end else if (!hold) begin
            par_live <= rd_en;
        end
    end

    assign par_err = par_live &&
                     (even_par(64'(ram_rdata[DATA_W-1:0])) != ram_rdata[DATA_W]);
`else
    assign ram_wdata = load_data;
    assign par_err   = 1'b0;
`endif

    assign instr = out_nop ? NOP_INSTR : ram_rdata[DATA_W-1:0];

    imem_ram #(
        .WORD_W(WORD_W),
        .IDX_W (IDX_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(load_addr[IDX_W-1:0]),
        .wdata(ram_wdata),
        .re   (rd_en),
        .raddr(fetch_pc[IDX_W-1:0]),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_imem_loadable.sv
// Directed table-driven bench for imem_loadable (DEPTH=64, 8-bit words).
// The parity sequence is compiled in when IMEM_PARITY_EN is defined.
module tb_imem_loadable;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_en = 1'b0, load_we = 1'b0;
    logic [7:0] load_addr = '0, load_data = '0;
    logic       load_done;
    logic [8:0] load_count;
    logic       fetch_req = 1'b0;
    logic [7:0] fetch_pc = '0;
    logic       stall = 1'b0, flush = 1'b0;
    logic [7:0] instr;
    logic       instr_valid, addr_err, par_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_loadable #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .DEPTH    (64),
        .NOP_INSTR(8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_done  (load_done),
        .load_count (load_count),
        .fetch_req  (fetch_req),
        .fetch_pc   (fetch_pc),
        .stall      (stall),
        .flush      (flush),
        .instr      (instr),
        .instr_valid(instr_valid),
        .addr_err   (addr_err),
        .par_err    (par_err)
    );

    typedef struct {
        logic       le, we;
        logic [7:0] la, ld;
        logic       fr;
        logic [7:0] pc;
        logic       st, fl;
        logic [7:0] e_instr;
        logic       e_valid, e_aerr, e_done;
        logic [8:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic le, we, input logic [7:0] la, ld,
                                input logic fr, input logic [7:0] pc, input logic st, fl,
                                input logic [7:0] ei, input logic ev, ea, ed,
                                input logic [8:0] ec);
        vec_t v;
        v.le = le; v.we = we; v.la = la; v.ld = ld; v.fr = fr; v.pc = pc;
        v.st = st; v.fl = fl; v.e_instr = ei; v.e_valid = ev; v.e_aerr = ea;
        v.e_done = ed; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic le, we, input logic [7:0] la, ld,
                         input logic fr, input logic [7:0] pc, input logic st, fl);
        load_en = le; load_we = we; load_addr = la; load_data = ld;
        fetch_req = fr; fetch_pc = pc; stall = st; flush = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ei, input logic ev, ea, ed,
                           input logic [8:0] ec, input logic ep);
        chk({tag, " instr"}, 32'(instr), 32'(ei));
        chk({tag, " valid"}, 32'(instr_valid), 32'(ev));
        chk({tag, " addr_err"}, 32'(addr_err), 32'(ea));
        chk({tag, " load_done"}, 32'(load_done), 32'(ed));
        chk({tag, " load_count"}, 32'(load_count), 32'(ec));
        chk({tag, " par_err"}, 32'(par_err), 32'(ep));
    endtask

    initial begin
        // Expected outputs are those seen just after the edge that samples the row.
        //             le we la     ld     fr pc     st fl   instr  v  a  d  cnt
        vecs.push_back(mk(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 9'd0));
        vecs.push_back(mk(1, 1, 8'h00, 8'h21, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 9'd1));
        vecs.push_back(mk(1, 1, 8'h01, 8'h61, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 9'd2));
        vecs.push_back(mk(1, 1, 8'h02, 8'h0C, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 9'd3));
        vecs.push_back(mk(1, 1, 8'h03, 8'hC1, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 9'd4));
        vecs.push_back(mk(1, 1, 8'h04, 8'h4B, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 9'd5));
        vecs.push_back(mk(1, 1, 8'h05, 8'h19, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 9'd6));
        vecs.push_back(mk(1, 1, 8'h50, 8'hFF, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 9'd6));
        vecs.push_back(mk(1, 1, 8'h40, 8'hEE, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 9'd6));
        vecs.push_back(mk(1, 0, 8'h06, 8'hAA, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 0, 8'h21, 1, 0, 0, 9'd6));
        vecs.push_back(mk(0, 1, 8'h01, 8'hFF, 1, 8'h01, 0, 0, 8'h61, 1, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h02, 0, 0, 8'h0C, 1, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h03, 0, 0, 8'hC1, 1, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h04, 0, 0, 8'h4B, 1, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h05, 0, 0, 8'h19, 1, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h19, 0, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h03, 0, 0, 8'hC1, 1, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h04, 1, 0, 8'hC1, 1, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h04, 1, 0, 8'hC1, 1, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h04, 1, 0, 8'hC1, 1, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h04, 0, 0, 8'h4B, 1, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h02, 1, 1, 8'h00, 0, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h50, 0, 0, 8'h00, 1, 1, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 0, 8'h21, 1, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h40, 0, 0, 8'h00, 1, 1, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h01, 1, 0, 8'h00, 1, 1, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 9'd6));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h01, 0, 0, 8'h61, 1, 0, 0, 9'd6));
        vecs.push_back(mk(1, 0, 8'h00, 8'h00, 1, 8'h02, 0, 0, 8'h00, 0, 0, 0, 9'd0));
        vecs.push_back(mk(1, 1, 8'h40, 8'h77, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 9'd0));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 9'd0));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 9'd0));

        // Reset with non-trivial inputs present.
        drive(1, 1, 8'h07, 8'h99, 1, 8'h00, 0, 0);
        tick; tick;
        chk_out("reset", 8'h00, 0, 0, 0, 9'd0, 0);
        drive(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].le, vecs[i].we, vecs[i].la, vecs[i].ld,
                  vecs[i].fr, vecs[i].pc, vecs[i].st, vecs[i].fl);
            tick;
            chk_out($sformatf("row%0d", i), vecs[i].e_instr, vecs[i].e_valid,
                    vecs[i].e_aerr, vecs[i].e_done, vecs[i].e_cnt, 1'b0);
        end

        // Reset in the middle of a load: earlier writes survive, the write during reset is lost.
        drive(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0); tick;
        drive(1, 1, 8'h00, 8'h33, 0, 8'h00, 0, 0); tick;
        drive(1, 1, 8'h01, 8'h44, 0, 8'h00, 0, 0); tick;
        drive(1, 1, 8'h02, 8'h55, 0, 8'h00, 0, 0); tick;
        chk("midload count", 32'(load_count), 32'd3);
        rst = 1'b0;
        drive(1, 1, 8'h03, 8'h66, 0, 8'h00, 0, 0); tick;
        chk_out("midrst1", 8'h00, 0, 0, 0, 9'd0, 0);
        drive(0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 0); tick;
        chk_out("midrst2", 8'h00, 0, 0, 0, 9'd0, 0);
        rst = 1'b1;
        drive(0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 0); tick;
        chk_out("after_rst pc0", 8'h33, 1, 0, 0, 9'd0, 0);
        drive(0, 0, 8'h00, 8'h00, 1, 8'h01, 0, 0); tick;
        chk_out("after_rst pc1", 8'h44, 1, 0, 0, 9'd0, 0);
        drive(0, 0, 8'h00, 8'h00, 1, 8'h02, 0, 0); tick;
        chk_out("after_rst pc2", 8'h55, 1, 0, 0, 9'd0, 0);
        drive(0, 0, 8'h00, 8'h00, 1, 8'h03, 0, 0); tick;
        chk_out("after_rst pc3", 8'hC1, 1, 0, 0, 9'd0, 0);
        drive(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0); tick;

`ifdef IMEM_PARITY_EN
        dut.u_ram.mem[1][0] = ~dut.u_ram.mem[1][0];
        drive(0, 0, 8'h00, 8'h00, 1, 8'h01, 0, 0); tick;
        chk_out("par flip", 8'h45, 1, 0, 0, 9'd0, 1);
        drive(0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 0); tick;
        chk_out("par stall", 8'h45, 1, 0, 0, 9'd0, 1);
        drive(0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 1); tick;
        chk_out("par flush", 8'h00, 0, 0, 0, 9'd0, 0);
        drive(0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 0); tick;
        chk_out("par clean", 8'h33, 1, 0, 0, 9'd0, 0);
`else
        drive(0, 0, 8'h00, 8'h00, 1, 8'h01, 0, 0); tick;
        chk_out("nopar pc1", 8'h44, 1, 0, 0, 9'd0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
Parametrised, boot-loadable instruction memory for the pipelined core's fetch stage. Replaces the fixed 6-entry, 8-bit combinational program store with a DEPTH-entry RAM. The RAM is written through a load port and read through a registered fetch port with stall/flush handshake. Out-of-range program counters are detected and substituted with a NOP.

Parameters:
DATA_W, 8, instruction word width in bits
ADDR_W, 8, PC / address width in bits
DEPTH, 64, number of instruction words; must satisfy DEPTH <= 2**ADDR_W
NOP_INSTR, 0, encoding substituted on flush, out-of-range fetch and reset

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-low
load_en  in  1  request boot-load mode
load_we  in  1  write strobe, honoured only in LOAD
load_addr  in  ADDR_W  write address
load_data  in  DATA_W  write data
load_done  out  1  one-cycle pulse when LOAD exits
load_count  out  ADDR_W+1  number of accepted writes in the last/current load session
fetch_req  in  1  fetch request from PC stage
fetch_pc  in  ADDR_W  fetch address
stall  in  1  downstream stall; hold outputs
flush  in  1  branch/jump flush; kill pending instruction
instr  out  DATA_W  fetched instruction (registered)
instr_valid  out  1  instr is a valid fetch result
addr_err  out  1  one-cycle flag: accepted fetch had fetch_pc >= DEPTH
par_err  out  1  parity mismatch on fetched word (0 without PARITY_EN)

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE; instr=NOP_INSTR; instr_valid=0; addr_err=0; par_err=0; load_done=0; load_count=0.
  - RAM contents are not cleared; a partially written image survives a mid-load reset.
- FSM states IDLE, LOAD, RUN:
  - IDLE: load_en=1 -> LOAD (priority); else fetch_req=1 -> RUN, and that fetch is accepted in the same cycle.
  - LOAD: entering clears load_count to 0. Each cycle with load_we=1 and load_addr < DEPTH writes mem[load_addr]=load_data and increments load_count (saturating at 2**(ADDR_W+1)-1). Writes with load_addr >= DEPTH are dropped and not counted. load_en=0 -> IDLE with load_done=1 for exactly that next cycle. fetch_req is ignored; instr_valid=0.
  - RUN: load_en=1 -> LOAD next cycle; instr_valid cleared to 0, instr set to NOP_INSTR. Otherwise remain in RUN.
- Fetch, latency 1:
  - fetch_req=1, stall=0 and flush=0 in cycle N -> in N+1: instr=mem[fetch_pc], instr_valid=1.
  - fetch_req=0, stall=0 and flush=0 -> instr_valid=0 next cycle; instr keeps its last value.
- stall=1 (flush=0): instr, instr_valid, addr_err and par_err hold their values; fetch_req is not accepted.
- flush=1: next cycle instr=NOP_INSTR, instr_valid=0, addr_err=0. Overrides both stall and fetch_req.
- fetch_pc >= DEPTH on an accepted fetch: instr=NOP_INSTR, instr_valid=1, addr_err=1 for one cycle. The RAM is not read.
- Writes and reads never collide, because load_we is ignored outside LOAD.
- Back-to-back fetches are accepted every cycle (throughput 1/clk).

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined: each RAM word stores an extra even-parity bit computed at write. On an accepted fetch the parity is rechecked, and par_err=1 in N+1 on mismatch. instr is still delivered; par_err follows the same stall/flush rules as addr_err.
- Undefined: no parity storage; par_err tied to 0.

Decomposition:
- Shared package imem_pkg: state enum (IDLE, LOAD, RUN), default NOP_INSTR constant, and the parity function.
- One natural sub-module, imem_ram: single-write, single-registered-read RAM of DEPTH x (DATA_W + optional parity bit).
- The FSM, handshake and error logic stay in the top module.

Test Plan:
- Load 0x21,0x61,0x0C,0xC1,0x4B,0x19 to addresses 0..5, then drop load_en -> load_done pulses once, load_count=6. Fetch PC 0..5 back-to-back -> instr 0x21..0x19 on consecutive cycles, instr_valid=1 each cycle.
- Fetch PC=3, hold stall=1 for 3 cycles while fetch_pc changes to 4 -> instr stays 0xC1 with valid=1. After release, the next fetch returns mem[4]=0x4B.
- Fetch PC=2 with flush=1 and stall=1 in the same cycle -> next cycle instr=NOP_INSTR (0x00), instr_valid=0.
- DEPTH=64, fetch PC=0x50 -> instr=0x00, instr_valid=1, addr_err=1 for one cycle. Load write to 0x50 -> dropped, load_count unchanged.
- Reset (rst=0) after 3 of 6 load writes, then fetch PC 0..2 -> data written before reset returned. Outputs were at reset values during reset.
- With IMEM_PARITY_EN, force a bit flip in mem[1] via backdoor, then fetch PC=1 -> par_err=1 next cycle. Clean addresses -> par_err=0.
